div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage.
- It is the responder side of the EX divide stall handshake. The EX stage raises start while a divide instruction is held. The pipeline controller holds stall asserted while (ex_is_div_inst & ~div_done). The divider answers with a single-cycle done pulse carrying the result.
- A pipeline flush aborts any divide in progress.

---
 rtl/div_unit.sv | 84 ++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring RV32M divider (start/flush/op/dividend/divisor in; busy/done/result out)
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t          state_q, state_d;
  logic            rem_sel_q, neg_q, sgn_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q;
  logic            sgn_op, a_neg, b_neg, div0, ovf, special, last, ge;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, rem_n, quo_n, res_n;
  logic [XLEN:0]   sh, diff;
  always_comb begin
    sgn_op   = ~op[0];
    a_neg    = sgn_op & dividend[XLEN-1];
    b_neg    = sgn_op & divisor[XLEN-1];
    abs_a    = a_neg ? -dividend : dividend;
    abs_b    = b_neg ? -divisor : divisor;
    div0     = divisor == '0;
    ovf      = sgn_op & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);
    special  = div0 | ovf;
    spec_res = div0 ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
    sh       = {rem_q, quo_q[XLEN-1]};
    diff     = sh - {1'b0, dvs_q};
    ge       = ~diff[XLEN];
    rem_n    = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    quo_n    = {quo_q[XLEN-2:0], ge};
    res_n    = rem_sel_q ? (sgn_q ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
    last     = cnt_q == CW'(XLEN-1);
  end
  always_comb begin
    state_d = IDLE;
    if (!flush)
      state_d = state_q == IDLE ? (start ? (special ? DONE : CALC) : IDLE) :
                state_q == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_comb begin
    busy   = state_q == CALC;
    done   = state_q == DONE;
    result = res_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && !flush) begin
        rem_sel_q <= op[1];
        neg_q     <= a_neg ^ b_neg;
        sgn_q     <= a_neg;
        dvs_q     <= abs_b;
        rem_q     <= '0;
        quo_q     <= abs_a;
        cnt_q     <= '0;
        if (special) res_q <= spec_res;
      end else if (state_q == CALC && !flush) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 1'b1;
        if (last) res_q <= res_n;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;
  logic        busy, done;
  int          tests_run = 0;
  int          fails = 0;
  int          busy_seen;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    lat = 0;
    busy_seen = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_seen++;
    end while (!done && lat < 100);
    r = result;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_divu;
    logic [31:0] r;
    int lat;
    do_op(2'b01, 32'd100, 32'd7, r, lat);
    tests_run++; if (lat !== 33) begin fails++; $display("FAIL divu_latency got %0d want 33", lat); end
    tests_run++; if (r !== 32'd14) begin fails++; $display("FAIL divu_result got %0d want 14", r); end
    tests_run++; if (busy_seen !== 32) begin fails++; $display("FAIL divu_busy_cycles got %0d want 32", busy_seen); end
    do_op(2'b11, 32'd100, 32'd7, r, lat);
    tests_run++; if (r !== 32'd2) begin fails++; $display("FAIL remu_result got %0d want 2", r); end
  endtask

  task automatic test_signed;
    logic [31:0] r;
    int lat;
    do_op(2'b00, -32'sd7, 32'd2, r, lat);
    tests_run++; if (r !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg got %h want fffffffd", r); end
    do_op(2'b10, -32'sd7, 32'd2, r, lat);
    tests_run++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_neg got %h want ffffffff", r); end
    do_op(2'b10, 32'd7, -32'sd2, r, lat);
    tests_run++; if (r !== 32'd1) begin fails++; $display("FAIL rem_negdivisor got %h want 1", r); end
  endtask

  task automatic test_special;
    logic [31:0] r;
    int lat;
    do_op(2'b01, 32'd5, 32'd0, r, lat);
    tests_run++; if (lat !== 1) begin fails++; $display("FAIL div0_latency got %0d want 1", lat); end
    tests_run++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    do_op(2'b10, 32'd5, 32'd0, r, lat);
    tests_run++; if (r !== 32'd5) begin fails++; $display("FAIL rem_by0 got %h want 5", r); end
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    tests_run++; if (lat !== 1) begin fails++; $display("FAIL ovf_latency got %0d want 1", lat); end
    tests_run++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf got %h want 80000000", r); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    tests_run++; if (r !== 32'd0) begin fails++; $display("FAIL rem_ovf got %h want 0", r); end
  endtask

  task automatic test_flush;
    logic [31:0] r;
    int lat, pulses;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL flush_done got %0b want 0", done); end
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    tests_run++; if (pulses !== 0) begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", pulses); end
    do_op(2'b01, 32'd9, 32'd4, r, lat);
    tests_run++; if (r !== 32'd2) begin fails++; $display("FAIL after_flush got %0d want 2", r); end
    tests_run++; if (lat !== 33) begin fails++; $display("FAIL after_flush_latency got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back;
    int cyc, first, second;
    logic [31:0] r1, r2;
    logic after_done, after_busy;
    first = -1; second = -1; r1 = '0; r2 = '0; after_done = 1'b1; after_busy = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd20; divisor = 32'd3;
    for (cyc = 1; cyc <= 120 && second < 0; cyc++) begin
      @(negedge clk);
      if (first > 0 && cyc == first + 1) begin after_done = done; after_busy = busy; end
      if (done && first < 0) begin first = cyc; r1 = result; op = 2'b11; end
      else if (done && first > 0) begin second = cyc; r2 = result; end
    end
    start = 1'b0;
    tests_run++; if (first !== 33) begin fails++; $display("FAIL b2b_first_cycle got %0d want 33", first); end
    tests_run++; if (second - first !== 34) begin fails++; $display("FAIL b2b_spacing got %0d want 34", second - first); end
    tests_run++; if ({after_done, after_busy} !== 2'b00) begin fails++; $display("FAIL b2b_idle_gap got done=%0b busy=%0b want 0 0", after_done, after_busy); end
    tests_run++; if (r1 !== 32'd6) begin fails++; $display("FAIL b2b_divu got %0d want 6", r1); end
    tests_run++; if (r2 !== 32'd2) begin fails++; $display("FAIL b2b_remu got %0d want 2", r2); end
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %0b want 0", done); end
    tests_run++; if (result !== 32'd0) begin fails++; $display("FAIL rstmid_result got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] a, b, r, exp;
    logic [1:0] o;
    int lat, mode;
    for (int i = 0; i < 1500; i++) begin
      o = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      else if (mode == 3) begin a = 32'($urandom_range(0, 100)); b = -32'($urandom_range(1, 9)); end
      exp = ref_model(o, a, b);
      do_op(o, a, b, r, lat);
      tests_run++; if (r !== exp) begin fails++; $display("FAIL rand_result op=%0d a=%h b=%h got %h want %h", o, a, b, r, exp); end
      tests_run++; if (lat !== ref_lat(o, a, b)) begin fails++; $display("FAIL rand_latency op=%0d a=%h b=%h got %0d want %0d", o, a, b, lat, ref_lat(o, a, b)); end
    end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_signed;
    test_special;
    test_flush;
    test_back_to_back;
    test_rst_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
